// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared adder types and the chunk-add helper
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int MAX_CHUNK = 64;

    // Callers zero-extend narrower chunks and slice the result back down.
    function automatic logic [MAX_CHUNK:0] chunk_add(
        input logic [MAX_CHUNK-1:0] a,
        input logic [MAX_CHUNK-1:0] b,
        input logic                 cin
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_CHUNK{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational CHUNK-bit adder exposing the carry into its MSB
module adder_chunk
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    // The MSB is added separately so its carry-in is visible for overflow.
    if (CHUNK == 1) begin : g_bit
        assign msb_cin = cin;
    end else begin : g_low
        logic [MAX_CHUNK:0] low;
        logic               unused_hi;

        assign low              = chunk_add(MAX_CHUNK'(a[CHUNK-2:0]), MAX_CHUNK'(b[CHUNK-2:0]), cin);
        assign sum[CHUNK-2:0]   = low[CHUNK-2:0];
        assign msb_cin          = low[CHUNK-1];
        assign unused_hi        = ^low[MAX_CHUNK:CHUNK];
    end

    assign sum[CHUNK-1] = a[CHUNK-1] ^ b[CHUNK-1] ^ msb_cin;
    assign cout         = (a[CHUNK-1] & b[CHUNK-1]) | (msb_cin & (a[CHUNK-1] ^ b[CHUNK-1]));

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined chunked add/subtract with valid/ready; ADDER_OVF_EN adds overflow
module pipe_adder
    import adder_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] bits_a,
    input  logic [BITWIDTH-1:0] bits_b,
    input  logic                carry_in,
    input  op_e                 op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] sum,
    output logic                carry_out
`ifdef ADDER_OVF_EN
    ,
    output logic                overflow
`endif
);

    localparam int CHUNK = BITWIDTH / STAGES;

    if (STAGES < 1 || STAGES > BITWIDTH || (BITWIDTH % STAGES) != 0 || CHUNK > MAX_CHUNK) begin : g_param_check
        $error("pipe_adder: BITWIDTH must be a multiple of STAGES with chunks of at most 64 bits");
    end

    logic [BITWIDTH-1:0] b_eff;
    logic                cin_eff;
    logic [STAGES:0]     rdy;
    logic [STAGES-1:0]   vld;
    logic [STAGES-1:0]   c_r;
    logic [STAGES-1:0]   msb_c;
    logic                unused_msb;
    logic [BITWIDTH-1:0] a_r [STAGES];
    logic [BITWIDTH-1:0] b_r [STAGES];
    logic [BITWIDTH-1:0] s_r [STAGES];

    // Subtraction is A + ~B + 1, so carry_in is irrelevant for SUB.
    assign b_eff   = (op == OP_SUB) ? ~bits_b : bits_b;
    assign cin_eff = (op == OP_SUB) ? 1'b1 : carry_in;

    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];
    assign unused_msb  = ^msb_c;

`ifdef ADDER_OVF_EN
    logic ovf_r;
    assign overflow = ovf_r;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;

        logic [BITWIDTH-1:0] a_in, b_in, s_in, s_nx;
        logic [CHUNK-1:0]    cs;
        logic                c_in, v_in, co;

        if (k == 0) begin : g_head
            assign a_in = bits_a;
            assign b_in = b_eff;
            assign s_in = '0;
            assign c_in = cin_eff;
            assign v_in = in_valid;
        end else begin : g_link
            assign a_in = a_r[k-1];
            assign b_in = b_r[k-1];
            assign s_in = s_r[k-1];
            assign c_in = c_r[k-1];
            assign v_in = vld[k-1];
        end

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a       (a_in[LO +: CHUNK]),
            .b       (b_in[LO +: CHUNK]),
            .cin     (c_in),
            .sum     (cs),
            .cout    (co),
            .msb_cin (msb_c[k])
        );

        always_comb begin
            s_nx             = s_in;
            s_nx[LO +: CHUNK] = cs;
        end

        assign rdy[k] = !vld[k] || rdy[k+1];

        // Data registers only move with a valid beat so idle outputs keep their last value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld[k] <= 1'b0;
                c_r[k] <= 1'b0;
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end else if (rdy[k]) begin
                vld[k] <= v_in;
                if (v_in) begin
                    c_r[k] <= co;
                    a_r[k] <= a_in;
                    b_r[k] <= b_in;
                    s_r[k] <= s_nx;
                end
            end
        end

`ifdef ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (rdy[k] && v_in) begin
                    ovf_r <= msb_c[k] ^ co;
                end
            end
        end
`endif
    end

    assign out_valid = vld[STAGES-1];
    assign sum       = s_r[STAGES-1];
    assign carry_out = c_r[STAGES-1];

endmodule
